// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - multi-lane in-order retire reorder buffer
//
// Purpose: circular buffer of DEPTH entries. Up to WIDTH entries are
// allocated per cycle at the tail, completed out of order by CDB writebacks,
// and retired in order from the head, up to WIDTH per cycle.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             (only with ROB_FLUSH_EN) return to the reset state
//   alloc_valid/rd    per-lane allocate request and destination register
//   alloc_ready/tag   room for WIDTH entries; tag offered to each lane
//   wb_valid/tag/data per-lane writeback broadcast
//   commit_valid/rd/data/tag  in-order retire lanes (prefix from lane 0)
//   count, empty, full        occupancy
//
// Configuration macro: ROB_FLUSH_EN adds the flush input.

module reorder_buffer #(
  parameter int  DEPTH  = 16,
  parameter int  WIDTH  = 2,
  parameter int  DATA_W = 32,
  localparam int TAG_W  = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef ROB_FLUSH_EN
  input  logic                    flush,
`endif
  input  logic [WIDTH-1:0]        alloc_valid,
  input  logic [WIDTH*5-1:0]      alloc_rd,
  output logic                    alloc_ready,
  output logic [WIDTH*TAG_W-1:0]  alloc_tag,
  input  logic [WIDTH-1:0]        wb_valid,
  input  logic [WIDTH*TAG_W-1:0]  wb_tag,
  input  logic [WIDTH*DATA_W-1:0] wb_data,
  output logic [WIDTH-1:0]        commit_valid,
  output logic [WIDTH*5-1:0]      commit_rd,
  output logic [WIDTH*DATA_W-1:0] commit_data,
  output logic [WIDTH*TAG_W-1:0]  commit_tag,
  output logic [TAG_W:0]          count,
  output logic                    empty,
  output logic                    full
);

  localparam int PTR_W = TAG_W + 1;
  localparam int CNT_W = 3;
  localparam logic [PTR_W-1:0] READY_MAX = PTR_W'(DEPTH - WIDTH);

  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [DEPTH-1:0]  r_busy;
  logic [DEPTH-1:0]  r_done;
  logic [4:0]        r_rd   [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];

  logic              w_clear;
  logic              w_commit_en;
  logic [PTR_W-1:0]  w_count;
  logic [TAG_W-1:0]  w_alloc_idx  [WIDTH];
  logic [TAG_W-1:0]  w_commit_idx [WIDTH];
  logic [WIDTH-1:0]  w_alloc_lane;
  logic [WIDTH-1:0]  w_commit_lane;
  logic [CNT_W-1:0]  w_alloc_n;
  logic [CNT_W-1:0]  w_commit_n;
  logic              w_alloc_run;
  logic              w_commit_run;

`ifdef ROB_FLUSH_EN
  assign w_clear     = rst | flush;
  assign w_commit_en = ~flush;
`else
  assign w_clear     = rst;
  assign w_commit_en = 1'b1;
`endif

  // Wrap bits make tail-head an exact occupancy, 0..DEPTH.
  assign w_count     = r_tail - r_head;
  assign count       = w_count;
  assign empty       = (w_count == '0);
  assign full        = (r_head[TAG_W-1:0] == r_tail[TAG_W-1:0]) &&
                       (r_head[TAG_W] != r_tail[TAG_W]);
  // Registered occupancy only: slots freed by this cycle's commit do not count.
  assign alloc_ready = (w_count <= READY_MAX);

  // Both allocate and commit take a contiguous prefix of lanes; the running
  // AND drops every lane above the first one that cannot proceed.
  always_comb begin
    w_alloc_run  = alloc_ready;
    w_commit_run = w_commit_en;
    w_alloc_n    = '0;
    w_commit_n   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_alloc_idx[i]  = r_tail[TAG_W-1:0] + TAG_W'(i);
      w_commit_idx[i] = r_head[TAG_W-1:0] + TAG_W'(i);
      w_alloc_run     = w_alloc_run & alloc_valid[i];
      w_commit_run    = w_commit_run & r_busy[w_commit_idx[i]] & r_done[w_commit_idx[i]];
      w_alloc_lane[i]  = w_alloc_run;
      w_commit_lane[i] = w_commit_run;
      w_alloc_n  = w_alloc_n + CNT_W'(w_alloc_run);
      w_commit_n = w_commit_n + CNT_W'(w_commit_run);
      alloc_tag[i*TAG_W +: TAG_W]     = w_alloc_idx[i];
      commit_tag[i*TAG_W +: TAG_W]    = w_commit_idx[i];
      commit_rd[i*5 +: 5]             = r_rd[w_commit_idx[i]];
      commit_data[i*DATA_W +: DATA_W] = r_data[w_commit_idx[i]];
    end
  end

  assign commit_valid = w_commit_lane;

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_head <= '0;
      r_tail <= '0;
      r_busy <= '0;
      r_done <= '0;
    end else begin
      // Highest lane first so the lowest lane's write lands last and wins
      // when two lanes name the same tag. Only already-busy entries accept
      // results, which also rejects entries allocated in this same cycle.
      for (int j = WIDTH - 1; j >= 0; j--) begin
        if (wb_valid[j] && r_busy[wb_tag[j*TAG_W +: TAG_W]]) begin
          r_done[wb_tag[j*TAG_W +: TAG_W]] <= 1'b1;
          r_data[wb_tag[j*TAG_W +: TAG_W]] <= wb_data[j*DATA_W +: DATA_W];
        end
      end
      // Retire after writeback so a late result cannot revive a freed entry.
      for (int i = 0; i < WIDTH; i++) begin
        if (w_commit_lane[i]) begin
          r_busy[w_commit_idx[i]] <= 1'b0;
          r_done[w_commit_idx[i]] <= 1'b0;
        end
      end
      // Allocation only targets free entries, so it never collides with
      // the retire or writeback updates above.
      for (int i = 0; i < WIDTH; i++) begin
        if (w_alloc_lane[i]) begin
          r_busy[w_alloc_idx[i]] <= 1'b1;
          r_done[w_alloc_idx[i]] <= 1'b0;
          r_rd[w_alloc_idx[i]]   <= alloc_rd[i*5 +: 5];
        end
      end
      r_head <= r_head + PTR_W'(w_commit_n);
      r_tail <= r_tail + PTR_W'(w_alloc_n);
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - self-checking bench for reorder_buffer
module tb_reorder_buffer;
  localparam int DEPTH  = 16;
  localparam int WIDTH  = 2;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [WIDTH-1:0]        alloc_valid;
  logic [WIDTH*5-1:0]      alloc_rd;
  logic                    alloc_ready;
  logic [WIDTH*TAG_W-1:0]  alloc_tag;
  logic [WIDTH-1:0]        wb_valid;
  logic [WIDTH*TAG_W-1:0]  wb_tag;
  logic [WIDTH*DATA_W-1:0] wb_data;
  logic [WIDTH-1:0]        commit_valid;
  logic [WIDTH*5-1:0]      commit_rd;
  logic [WIDTH*DATA_W-1:0] commit_data;
  logic [WIDTH*TAG_W-1:0]  commit_tag;
  logic [TAG_W:0]          count;
  logic                    empty;
  logic                    full;

  int checks = 0;
  int errors = 0;

  reorder_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .commit_valid(commit_valid), .commit_rd(commit_rd),
    .commit_data(commit_data), .commit_tag(commit_tag),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  // Model: the in-flight instructions in program order, oldest first.
  typedef struct {
    logic [3:0]  tag;
    logic [4:0]  rd;
    bit          done;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];
  int   next_tag = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_update();
    int   nc;
    int   size0;
    bit   run;
    logic [3:0] t;
    ent_t e;
    if (rst) begin
      q.delete();
      next_tag = 0;
      return;
    end
    size0 = q.size();
    nc = 0;
    run = 1;
    for (int i = 0; i < WIDTH; i++) begin
      if (run && i < q.size() && q[i].done) nc++;
      else run = 0;
    end
    for (int j = 0; j < WIDTH; j++) begin
      if (wb_valid[j]) begin
        t = wb_tag[j*TAG_W +: TAG_W];
        if (j == 1 && wb_valid[0] && wb_tag[3:0] == t) continue;
        for (int k = 0; k < q.size(); k++) begin
          if (q[k].tag == t) begin
            q[k].done = 1;
            q[k].data = wb_data[j*DATA_W +: DATA_W];
          end
        end
      end
    end
    repeat (nc) void'(q.pop_front());
    if (DEPTH - size0 >= WIDTH) begin
      run = 1;
      for (int i = 0; i < WIDTH; i++) begin
        if (run && alloc_valid[i]) begin
          e.tag  = 4'(next_tag);
          e.rd   = alloc_rd[i*5 +: 5];
          e.done = 0;
          e.data = '0;
          q.push_back(e);
          next_tag = (next_tag + 1) % DEPTH;
        end else begin
          run = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [1:0] ev;
    bit run;
    check("count", 64'(count), 64'(q.size()));
    check("empty", 64'(empty), 64'(q.size() == 0));
    check("full", 64'(full), 64'(q.size() == DEPTH));
    check("alloc_ready", 64'(alloc_ready), 64'((DEPTH - q.size()) >= WIDTH));
    for (int i = 0; i < WIDTH; i++)
      check($sformatf("alloc_tag%0d", i), 64'(alloc_tag[i*TAG_W +: TAG_W]), 64'((next_tag + i) % DEPTH));
    ev = '0;
    run = 1;
    for (int i = 0; i < WIDTH; i++) begin
      run = run && (i < q.size()) && q[i].done;
      ev[i] = run;
    end
    check("commit_valid", 64'(commit_valid), 64'(ev));
    for (int i = 0; i < WIDTH; i++) begin
      if (ev[i]) begin
        check($sformatf("commit_tag%0d", i), 64'(commit_tag[i*TAG_W +: TAG_W]), 64'(q[i].tag));
        check($sformatf("commit_rd%0d", i), 64'(commit_rd[i*5 +: 5]), 64'(q[i].rd));
        check($sformatf("commit_data%0d", i), 64'(commit_data[i*DATA_W +: DATA_W]), 64'(q[i].data));
      end
    end
  endtask

  // Inputs are already driven; the model advances with the DUT edge, then
  // outputs are compared at the following falling edge.
  task automatic step();
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_idle();
    alloc_valid = '0;
    alloc_rd    = '0;
    wb_valid    = '0;
    wb_tag      = '0;
    wb_data     = '0;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic do_alloc(input logic [1:0] v);
    set_idle();
    alloc_valid = v;
    alloc_rd    = 10'($urandom);
    step();
  endtask

  task automatic do_wb(input logic [3:0] t);
    set_idle();
    wb_valid     = 2'b01;
    wb_tag[3:0]  = t;
    wb_data[31:0] = $urandom;
    step();
  endtask

  initial begin
    int pend[$];
    int r;
    rst = 1'b1;
    set_idle();

    // Reset state.
    do_reset();
    check("rst_commit_valid", 64'(commit_valid), 64'd0);
    check("rst_alloc_ready", 64'(alloc_ready), 64'd1);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_alloc_tag", 64'(alloc_tag), 64'h10);

    // Fill: 8 cycles of two lanes.
    for (int i = 0; i < 8; i++) do_alloc(2'b11);
    check("fill_count", 64'(count), 64'd16);
    check("fill_full", 64'(full), 64'd1);
    check("fill_ready", 64'(alloc_ready), 64'd0);

    // Out-of-order completion, in-order retire.
    do_reset();
    do_alloc(2'b11);
    do_alloc(2'b01);
    do_wb(4'd2);
    check("ooo_none", 64'(commit_valid), 64'd0);
    do_wb(4'd0);
    check("ooo_first_valid", 64'(commit_valid), 64'b01);
    check("ooo_first_tag", 64'(commit_tag[3:0]), 64'd0);
    do_wb(4'd1);
    check("ooo_pair_valid", 64'(commit_valid), 64'b11);
    check("ooo_pair_tag", 64'(commit_tag), 64'h21);
    set_idle();
    step();
    check("ooo_drained", 64'(empty), 64'd1);

    // Non-prefix allocate request and the count=15 ready boundary.
    do_reset();
    do_alloc(2'b10);
    check("gap_count", 64'(count), 64'd0);
    check("gap_tag", 64'(alloc_tag), 64'h10);
    for (int i = 0; i < 7; i++) do_alloc(2'b11);
    do_alloc(2'b01);
    check("c15_count", 64'(count), 64'd15);
    check("c15_ready", 64'(alloc_ready), 64'd0);
    do_alloc(2'b11);
    check("c15_hold", 64'(count), 64'd15);

    // Simultaneous allocate and commit at count=14, with tag wrap.
    do_reset();
    for (int i = 0; i < 7; i++) do_alloc(2'b11);
    set_idle();
    wb_valid = 2'b11; wb_tag = 8'h10; wb_data = {$urandom, $urandom};
    step();
    check("wrap_cv", 64'(commit_valid), 64'b11);
    do_alloc(2'b11);
    check("wrap_count1", 64'(count), 64'd14);
    check("wrap_tag1", 64'(alloc_tag), 64'h10);
    set_idle();
    wb_valid = 2'b11; wb_tag = 8'h32; wb_data = {$urandom, $urandom};
    step();
    do_alloc(2'b11);
    check("wrap_count2", 64'(count), 64'd14);
    check("wrap_tag2", 64'(alloc_tag), 64'h32);

    // Reset with 10 busy entries, then a stale writeback.
    do_reset();
    for (int i = 0; i < 5; i++) do_alloc(2'b11);
    check("busy10_count", 64'(count), 64'd10);
    do_reset();
    check("clr_empty", 64'(empty), 64'd1);
    check("clr_count", 64'(count), 64'd0);
    do_wb(4'd3);
    set_idle();
    step();
    check("stale_cv", 64'(commit_valid), 64'd0);

    // Randomized traffic, including duplicate and stray writeback tags.
    for (int c = 0; c < 4000; c++) begin
      set_idle();
      rst = ($urandom_range(0, 399) == 0);
      alloc_valid = 2'($urandom);
      alloc_rd    = 10'($urandom);
      pend.delete();
      foreach (q[k]) if (!q[k].done) pend.push_back(int'(q[k].tag));
      for (int j = 0; j < WIDTH; j++) begin
        r = $urandom_range(0, 9);
        if (r < 6 && pend.size() > 0) begin
          wb_valid[j] = 1'b1;
          wb_tag[j*TAG_W +: TAG_W] = 4'(pend[$urandom_range(0, pend.size() - 1)]);
        end else if (r == 6) begin
          wb_valid[j] = 1'b1;
          wb_tag[j*TAG_W +: TAG_W] = 4'($urandom);
        end else if (r == 7 && j == 1 && wb_valid[0]) begin
          wb_valid[j] = 1'b1;
          wb_tag[j*TAG_W +: TAG_W] = wb_tag[3:0];
        end
        wb_data[j*DATA_W +: DATA_W] = $urandom;
      end
      step();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, entry count, a power of two and at least 4.
REQ-002 SHALL have parameter WIDTH, default 2, the number of allocate, writeback and commit lanes, from 1 to 4.
REQ-003 SHALL have parameter DATA_W, default 32, result width; TAG_W SHALL equal log2(DEPTH).
REQ-004 SHALL have port clk, input, 1, the only clock.
REQ-005 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port alloc_valid, input, WIDTH, per-lane allocate request; lane 0 is oldest.
REQ-007 SHALL have port alloc_rd, input, WIDTH*5, destination architectural register per lane.
REQ-008 SHALL have port alloc_ready, output, 1, high when free entries >= WIDTH.
REQ-009 SHALL have port alloc_tag, output, WIDTH*TAG_W, tag offered to each lane: (tail+i) mod DEPTH.
REQ-010 SHALL have port wb_valid, input, WIDTH, per-lane result broadcast from the CDB.
REQ-011 SHALL have port wb_tag, input, WIDTH*TAG_W, entry being completed on each writeback lane.
REQ-012 SHALL have port wb_data, input, WIDTH*DATA_W, result value on each writeback lane.
REQ-013 SHALL have port commit_valid, output, WIDTH, in-order retire lanes; asserted lanes always form a prefix starting at lane 0.
REQ-014 SHALL have port commit_rd, output, WIDTH*5, destination register of each retiring entry.
REQ-015 SHALL have port commit_data, output, WIDTH*DATA_W, result value of each retiring entry.
REQ-016 SHALL have port commit_tag, output, WIDTH*TAG_W, tag of each retiring entry.
REQ-017 SHALL have port count, output, TAG_W+1, occupied entries; plus empty (output, 1) and full (output, 1).

Function
REQ-018 SHALL form a circular buffer with head and tail pointers, each TAG_W+1 bits with a wrap bit; full when the indices are equal and the wrap bits differ.
REQ-019 SHALL allocate only when alloc_ready=1, taking the contiguous prefix of set alloc_valid bits; a valid lane above a cleared lane SHALL be ignored.
REQ-020 SHALL mark each allocated entry busy and not done at the clock edge, and SHALL advance tail by the number of lanes allocated, modulo 2*DEPTH.
REQ-021 SHALL, on wb_valid, set done and store wb_data only if the target entry is already busy; a writeback to a non-busy entry, or to an entry allocated in the same cycle, SHALL be ignored.
REQ-022 SHALL, when two writeback lanes carry the same tag in one cycle, take the lowest-numbered lane.
REQ-023 SHALL assert commit_valid[i] combinationally from registered state only, when entries head..head+i are all busy and done.
REQ-024 SHALL therefore make a writeback visible to commit one cycle later, never in the same cycle.
REQ-025 SHALL, at the edge, clear busy on every committed entry and advance head by the commit count.
REQ-026 SHALL update count as count + allocated - committed when allocation and commit happen in the same cycle.
REQ-027 SHALL compute alloc_ready from the registered count only; entries freed by the same-cycle commit SHALL NOT be counted.
REQ-028 SHALL pass rd=x0 entries through commit unchanged; filtering them is the register file's job.

Reset
REQ-029 SHALL, while rst=1, set head=0, tail=0 and count=0, clear every busy and done bit, and override all alloc and writeback inputs.
REQ-030 SHALL drive these output values in the cycle after reset: commit_valid=0, alloc_ready=1, empty=1, full=0, alloc_tag lane i = i.

Configuration
REQ-031 SHALL, with ROB_FLUSH_EN defined, add an input port flush (1 bit) that returns the block to the reset state at the next edge, with priority over alloc, writeback and commit; commit_valid SHALL be forced to 0 while flush=1.
REQ-032 SHALL, without ROB_FLUSH_EN, have no flush port and no flush logic.

Verification (DEPTH=16, WIDTH=2)
REQ-033 SHALL cover: after reset, allocate 2 lanes per cycle for 8 cycles -> tags 0..15 issued, then count=16, full=1, alloc_ready=0.
REQ-034 SHALL cover: allocate tags 0,1,2; write back 2, then 0, then 1 in separate cycles -> tag 0 commits alone one cycle after its writeback, then tags 1 and 2 commit together one cycle after tag 1's writeback.
REQ-035 SHALL cover: alloc_valid=2'b10 -> no allocation and tail unchanged; with count=15 -> alloc_ready=0.
REQ-036 SHALL cover: with count=14, 2 allocations and 2 commits in the same cycle -> count stays 14 and tags wrap from 15 to 0 correctly.
REQ-037 SHALL cover: rst, or flush with ROB_FLUSH_EN, asserted with 10 entries busy -> next cycle empty=1, count=0, and a stale writeback to tag 3 causes no commit.
